// File: rtl/vlg_echo_pkg.sv
// -----------------------------------------------------------------------------
// vlg_echo_pkg
// Shared definitions for the multi-channel ultrasonic echo timer:
//   - sequencer state encoding
//   - default timing constants in 1 us ticks
//   - distance conversion factor used by the downstream distance logic
// -----------------------------------------------------------------------------
package vlg_echo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TRIG = 3'd1,
        ST_WAIT = 3'd2,
        ST_MEAS = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    // 26011 ticks of round-trip echo correspond to 4500 mm of range.
    localparam int unsigned T_MAX_DEF   = 26011;
    localparam int unsigned TRIG_US_DEF = 10;
    localparam int unsigned GAP_US_DEF  = 60000;

    // 0.173 mm per us of echo, unsigned Q0.16 (0.173 * 65536 rounded).
    localparam int unsigned MM_PER_US_Q16 = 11338;

endpackage

// File: rtl/vlg_echo_sync.sv
// -----------------------------------------------------------------------------
// vlg_echo_sync
// Brings one asynchronous echo input into the i_clk domain and flags its edges.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_echo   raw asynchronous echo pin
//   o_pos    one-cycle pulse on a rising edge of the synchronised echo
//   o_neg    one-cycle pulse on a falling edge of the synchronised echo
// Pin-to-pulse latency is SYNC_STAGES + 1 clock cycles.
// -----------------------------------------------------------------------------
module vlg_echo_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_echo,
    output logic o_pos,
    output logic o_neg
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   pos_q, pos_d;
    logic                   neg_q, neg_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_echo};
        level_d = sync_q[SYNC_STAGES-1];
        pos_d   = sync_q[SYNC_STAGES-1] & ~level_q;
        neg_d   = ~sync_q[SYNC_STAGES-1] & level_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign o_pos = pos_q;
    assign o_neg = neg_q;

endmodule

// File: rtl/vlg_echo_mch.sv
// -----------------------------------------------------------------------------
// vlg_echo_mch
// Multi-channel ultrasonic ranging sequencer and echo timer. Triggers each of
// CH_NUM sensors in turn, times its echo in 1 us ticks, flags missing or
// over-range echoes and leaves a quiet gap before the next channel.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_clk_en   1 us tick, one i_clk cycle wide
//   i_start    start one sweep (ignored while busy)
//   i_cont     restart the sweep after the last channel's gap
//   i_echo     asynchronous echo inputs, one per channel
//   o_trig     trigger outputs, at most one high
//   o_t_us     per-channel result, channel k at [k*CNT_W +: CNT_W]
//   o_valid    one-cycle pulse when channel k's result updates
//   o_timeout  channel k's latest result is a timeout / saturation
//   o_busy     sequencer is not idle
// -----------------------------------------------------------------------------
module vlg_echo_mch
    import vlg_echo_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 16,
    parameter int T_MAX       = T_MAX_DEF,
    parameter int TRIG_US     = TRIG_US_DEF,
    parameter int GAP_US      = GAP_US_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clk_en,
    input  logic                    i_start,
    input  logic                    i_cont,
    input  logic [CH_NUM-1:0]       i_echo,
    output logic [CH_NUM-1:0]       o_trig,
    output logic [CH_NUM*CNT_W-1:0] o_t_us,
    output logic [CH_NUM-1:0]       o_valid,
    output logic [CH_NUM-1:0]       o_timeout,
    output logic                    o_busy
);

    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CH_NUM - 1);
    localparam logic [CNT_W-1:0] TMAX_C  = CNT_W'(T_MAX);
    localparam logic [CNT_W-1:0] TRIG_C  = CNT_W'(TRIG_US);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_US);

    logic [CH_NUM-1:0] pos_v, neg_v;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_sync
        vlg_echo_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_echo  (i_echo[g]),
            .o_pos   (pos_v[g]),
            .o_neg   (neg_v[g])
        );
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_adv;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  t_us_q [CH_NUM];
    logic [CNT_W-1:0]  t_us_d [CH_NUM];
    logic [CH_NUM-1:0] valid_q, valid_d;
    logic [CH_NUM-1:0] timeout_q, timeout_d;
    logic [CH_NUM-1:0] trig_q, trig_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        t_us_d    = t_us_q;
        timeout_d = timeout_q;
        valid_d   = '0;
        trig_d    = '0;
        // Each state only advances while below its own limit, so the counter
        // parks at the limit instead of wrapping.
        cnt_adv   = i_clk_en ? cnt_q + 1'b1 : cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_TRIG;
                    ch_d    = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_C) state_d = ST_WAIT;
                else                 cnt_d   = cnt_adv;
            end
            ST_WAIT: begin
                if (pos_v[ch_q]) begin
                    state_d = ST_MEAS;
                end else if (cnt_q == TMAX_C) begin
                    t_us_d[ch_q]    = TMAX_C;
                    timeout_d[ch_q] = 1'b1;
                    valid_d[ch_q]   = 1'b1;
                    state_d         = ST_GAP;
                end else begin
                    cnt_d = cnt_adv;
                end
            end
            ST_MEAS: begin
                // A falling edge in the same cycle as the limit still counts
                // as a genuine measurement.
                if (neg_v[ch_q]) begin
                    t_us_d[ch_q]    = cnt_q;
                    timeout_d[ch_q] = 1'b0;
                    valid_d[ch_q]   = 1'b1;
                    state_d         = ST_GAP;
                end else if (cnt_q == TMAX_C) begin
                    t_us_d[ch_q]    = TMAX_C;
                    timeout_d[ch_q] = 1'b1;
                    valid_d[ch_q]   = 1'b1;
                    state_d         = ST_GAP;
                end else begin
                    cnt_d = cnt_adv;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_C) begin
                    if (ch_q != CH_LAST) begin
                        ch_d    = ch_q + 1'b1;
                        state_d = ST_TRIG;
                    end else if (i_cont) begin
                        ch_d    = '0;
                        state_d = ST_TRIG;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_adv;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        // Trigger is registered from the next state so the pin is glitch-free.
        if (state_d == ST_TRIG) trig_d[ch_d] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            valid_q   <= '0;
            timeout_q <= '0;
            trig_q    <= '0;
            for (int k = 0; k < CH_NUM; k++) t_us_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            trig_q    <= trig_d;
            t_us_q    <= t_us_d;
        end
    end

    always_comb begin
        o_t_us = '0;
        for (int k = 0; k < CH_NUM; k++) o_t_us[k*CNT_W +: CNT_W] = t_us_q[k];
    end

    assign o_trig    = trig_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vlg_echo_mch.sv
// -----------------------------------------------------------------------------
// tb_vlg_echo_mch
// Directed sweeps against vlg_echo_mch with shortened limits. Each echo pulse
// the bench generates also queues the result it must produce; a compare
// process checks every cycle that results arrive in order with the right
// value/timeout and that every other channel holds its last result.
// -----------------------------------------------------------------------------
module tb_vlg_echo_mch;

    localparam int CH   = 4;
    localparam int CW   = 16;
    localparam int TMAX = 1200;
    localparam int TRIG = 10;
    localparam int GAP  = 200;
    localparam int LIM  = 4000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clk_en;
    logic              start;
    logic              cont;
    logic [CH-1:0]     echo;
    logic [CH-1:0]     o_trig;
    logic [CH*CW-1:0]  o_t_us;
    logic [CH-1:0]     o_valid;
    logic [CH-1:0]     o_timeout;
    logic              o_busy;

    vlg_echo_mch #(
        .CH_NUM(CH), .CNT_W(CW), .T_MAX(TMAX), .TRIG_US(TRIG),
        .GAP_US(GAP), .SYNC_STAGES(2)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clk_en  (clk_en),
        .i_start   (start),
        .i_cont    (cont),
        .i_echo    (echo),
        .o_trig    (o_trig),
        .o_t_us    (o_t_us),
        .o_valid   (o_valid),
        .o_timeout (o_timeout),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    // 1 us tick every second clock, changed just after the rising edge.
    initial begin
        clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1 clk_en = ~clk_en;
        end
    end

    typedef struct {
        int ch;
        int val;
        int tol;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    int   mdl_val [CH];
    int   mdl_tol [CH];
    bit   mdl_to  [CH];
    int   checks = 0;
    int   errors = 0;
    exp_t cmp_e;
    int   cmp_got;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < CH; k++) begin
            mdl_val[k] = 0;
            mdl_tol[k] = 0;
            mdl_to[k]  = 1'b0;
        end
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (o_trig != 0 || o_valid != 0 || o_timeout != 0 || o_t_us != 0 || o_busy) begin
                errors++;
                $display("FAIL reset_outputs: trig=%b valid=%b to=%b t_us=%h busy=%b, all must be 0",
                         o_trig, o_valid, o_timeout, o_t_us, o_busy);
            end
        end else begin
            checks++;
            if (!$onehot0(o_trig)) begin
                errors++;
                $display("FAIL trig_onehot: trig=%b, at most one bit allowed", o_trig);
            end
            checks++;
            if (!$onehot0(o_valid)) begin
                errors++;
                $display("FAIL valid_onehot: valid=%b, at most one bit allowed", o_valid);
            end
            for (int k = 0; k < CH; k++) begin
                cmp_got = int'(o_t_us[k*CW +: CW]);
                if (o_valid[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid: ch%0d value %0d, no result expected", k, cmp_got);
                    end else begin
                        cmp_e = exp_q.pop_front();
                        if (cmp_e.ch != k) begin
                            errors++;
                            $display("FAIL result_order: got ch%0d, expected ch%0d", k, cmp_e.ch);
                        end
                        checks++;
                        if (absd(cmp_got, cmp_e.val) > cmp_e.tol) begin
                            errors++;
                            $display("FAIL result_value ch%0d: got %0d, expected %0d +/-%0d",
                                     k, cmp_got, cmp_e.val, cmp_e.tol);
                        end
                        checks++;
                        if (o_timeout[k] != cmp_e.to) begin
                            errors++;
                            $display("FAIL result_timeout ch%0d: got %0b, expected %0b",
                                     k, o_timeout[k], cmp_e.to);
                        end
                        mdl_val[cmp_e.ch] = cmp_e.val;
                        mdl_tol[cmp_e.ch] = cmp_e.tol;
                        mdl_to[cmp_e.ch]  = cmp_e.to;
                    end
                end else begin
                    checks++;
                    if (absd(cmp_got, mdl_val[k]) > mdl_tol[k] || o_timeout[k] != mdl_to[k]) begin
                        errors++;
                        $display("FAIL hold ch%0d: got %0d/to=%0b, expected %0d +/-%0d/to=%0b",
                                 k, cmp_got, o_timeout[k], mdl_val[k], mdl_tol[k], mdl_to[k]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (!clk_en) @(negedge clk);
        end
    endtask

    task automatic start_sweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("trig0_after_start", int'(o_trig[0]), 1, 1);
        chk("busy_after_start", int'(o_busy), 1, 1);
    endtask

    // w < 0: no echo; w >= TMAX: saturating echo; gl >= 0: glitch that channel.
    task automatic run_ch(input int ch, input int w, input int gl);
        exp_t e;
        int   n;
        int   tt;
        e.ch  = ch;
        e.val = (w < 0 || w >= TMAX) ? TMAX : w;
        e.tol = (w < 0 || w >= TMAX) ? 0 : 1;
        e.to  = (w < 0 || w >= TMAX);
        exp_q.push_back(e);
        n = 0;
        while (!o_trig[ch] && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (!o_trig[ch]) begin
            chk($sformatf("trig%0d_rise_timeout", ch), 0, 1, 1);
            return;
        end
        tt = 0;
        n  = 0;
        while (o_trig[ch] && n < LIM) begin
            if (clk_en) tt++;
            @(negedge clk);
            n++;
        end
        chk($sformatf("trig%0d_ticks", ch), tt, TRIG, TRIG);
        if (w >= 0) begin
            ticks(5);
            echo[ch] = 1'b1;
            if (gl >= 0) begin
                ticks(20);
                echo[gl] = 1'b1;
                ticks(5);
                echo[gl] = 1'b0;
                ticks(w - 25);
            end else begin
                ticks(w);
            end
            echo[ch] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("busy_drops", int'(o_busy), 0, 0);
    endtask

    function automatic int res(input int k);
        return int'(o_t_us[k*CW +: CW]);
    endfunction

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        echo  = '0;
        model_clear();
        repeat (4) @(negedge clk);
        chk("rst_busy", int'(o_busy), 0, 0);
        chk("rst_trig", int'(o_trig), 0, 0);
        #2 rst_n = 1'b1;

        // Sweep 1: normal echo, short echo, no echo, saturating echo.
        start_sweep();
        run_ch(0, 1000, -1);
        run_ch(1, 50, -1);
        run_ch(2, -1, -1);
        run_ch(3, 1300, -1);
        wait_idle();
        chk("s1_ch0_val", res(0), 999, 1001);
        chk("s1_ch0_to", int'(o_timeout[0]), 0, 0);
        chk("s1_ch2_val", res(2), 1200, 1200);
        chk("s1_ch2_to", int'(o_timeout[2]), 1, 1);
        chk("s1_ch3_val", res(3), 1200, 1200);
        chk("s1_ch3_to", int'(o_timeout[3]), 1, 1);

        // Sweep 2: 100/200/300/400 with a start pulse while busy.
        start_sweep();
        run_ch(0, 100, -1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_ch(1, 200, -1);
        run_ch(2, 300, -1);
        run_ch(3, 400, -1);
        wait_idle();
        repeat (50) @(negedge clk);
        chk("s2_idle_trig", int'(o_trig), 0, 0);
        chk("s2_idle_busy", int'(o_busy), 0, 0);
        chk("s2_ch1_val", res(1), 199, 201);
        chk("s2_ch3_to", int'(o_timeout[3]), 0, 0);

        // Sweep 3: continuous mode for two passes, glitch on idle channel 3.
        cont = 1'b1;
        start_sweep();
        run_ch(0, 150, 3);
        run_ch(1, 250, -1);
        run_ch(2, 350, -1);
        run_ch(3, 450, -1);
        run_ch(0, 500, -1);
        cont = 1'b0;
        run_ch(1, 60, -1);
        run_ch(2, 70, -1);
        run_ch(3, 80, -1);
        wait_idle();
        chk("s3_ch0_val", res(0), 499, 501);

        // Reset in the middle of a measurement.
        start_sweep();
        n = 0;
        while (o_trig[0] && n < LIM) begin
            @(negedge clk);
            n++;
        end
        ticks(5);
        echo[0] = 1'b1;
        ticks(300);
        #2;
        model_clear();
        rst_n = 1'b0;
        #1;
        chk("midrst_trig", int'(o_trig), 0, 0);
        chk("midrst_t_us", (o_t_us == 0) ? 0 : 1, 0, 0);
        chk("midrst_valid", int'(o_valid), 0, 0);
        chk("midrst_timeout", int'(o_timeout), 0, 0);
        chk("midrst_busy", int'(o_busy), 0, 0);
        echo = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Fresh sweep after reset.
        start_sweep();
        run_ch(0, 120, -1);
        run_ch(1, 130, -1);
        run_ch(2, 140, -1);
        run_ch(3, 150, -1);
        wait_idle();
        chk("s5_ch3_val", res(3), 149, 151);
        repeat (5) @(negedge clk);
        chk("results_outstanding", exp_q.size(), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
